pll_sdram_reset_seq: RTL and testbench
======================================

Name: pll_sdram_reset_seq

Overview:
- Reset sequencer directly downstream of the SDRAM PLL.
- Consumes the PLL `locked` output and produces the active-high reset for logic clocked by the PLL's 100 MHz outputs.
- Drives the PLL's `rst` input: pulses it at power-up, after a lock timeout, and after lock loss.
- Runs on the free-running 50 MHz reference clock, so it keeps operating while the PLL is held in reset.

Parameters:
- SYNC_STAGES, 2: flop stages synchronizing pll_locked (≥2).
- PLL_RST_CYCLES, 8: refclk cycles pll_rst is held high per pulse (≥1).
- TIMEOUT_CYCLES, 50000: cycles waiting for lock before re-pulsing pll_rst (≥1).
- STABLE_CYCLES, 1024: consecutive cycles lock must stay high before release proceeds (≥1).
- HOLD_CYCLES, 16: extra cycles reset_out stays high after lock is stable (≥1).
- CNT_W, 17: state-counter width; must hold max(TIMEOUT_CYCLES, STABLE_CYCLES, HOLD_CYCLES, PLL_RST_CYCLES)-1.

Ports:
- refclk  in  1  50 MHz free-running reference clock; all flops on rising edge.
- rst  in  1  asynchronous, active-high reset; deassertion is synchronous to refclk (integrator's responsibility).
- pll_locked  in  1  PLL lock indicator, asynchronous to refclk.
- pll_rst  out  1  reset to the PLL, active-high.
- reset_out  out  1  active-high reset for the 100 MHz domains; consumers resynchronize deassertion locally.
- ready  out  1  high only while the PLL is locked and released.
- timeout_count  out  8  saturating count of lock timeouts.
- loss_count  out  8  saturating count of lock losses while in RUN.
- state  out  3  current FSM state, for debug.

Behaviour:
- **Reset values.** rst high forces, immediately with no clock edge: state=PLL_RST (0), cnt=0, sync chain=0, pll_rst=1, reset_out=1, ready=0, both counts=0.
- **Synchronizer.** locked_s is the last stage of the SYNC_STAGES-flop chain. The FSM uses only locked_s.
- **Encoding.** PLL_RST=0, WAIT_LOCK=1, STABLE=2, HOLD=3, RUN=4. Codes 5-7 go to PLL_RST on the next edge.
- **Output registration.** All outputs are registered and are functions of the next state:
  - pll_rst=1 only in PLL_RST.
  - reset_out=0 only in RUN.
  - ready=1 only in RUN.
- **PLL_RST.**
  - cnt increments each cycle.
  - At cnt==PLL_RST_CYCLES-1: go to WAIT_LOCK, cnt=0.
  - pll_rst is high for exactly PLL_RST_CYCLES cycles.
- **WAIT_LOCK.**
  - locked_s=1: go to STABLE, cnt=0.
  - Otherwise, cnt==TIMEOUT_CYCLES-1: go to PLL_RST, cnt=0, timeout_count+1 (saturate at 255).
  - Otherwise: cnt+1.
- **STABLE.**
  - locked_s=0: go to WAIT_LOCK, cnt=0 (timeout window restarts; no count change).
  - Otherwise, cnt==STABLE_CYCLES-1: go to HOLD, cnt=0.
  - Otherwise: cnt+1.
- **HOLD.**
  - locked_s=0: go to WAIT_LOCK, cnt=0.
  - Otherwise, cnt==HOLD_CYCLES-1: go to RUN.
  - Otherwise: cnt+1.
- **RUN.**
  - locked_s=0: go to PLL_RST, cnt=0, loss_count+1 (saturate at 255).
  - reset_out rises and ready falls on that same edge.
- **Release latency.** pll_locked steady high from refclk edge S onward makes reset_out fall and ready rise at edge S+SYNC_STAGES+STABLE_CYCLES+HOLD_CYCLES (S counted as 0).
- **Loss latency.** pll_locked falling before edge L while in RUN makes reset_out rise at edge L+SYNC_STAGES.
- **Glitch immunity.** A lock glitch shorter than STABLE_CYCLES never deasserts reset_out.
- **Saturation.** Counters hold at 255 and never wrap. They clear only on rst.
- **Reset mid-operation.** rst in any state aborts the current sequence, including mid pll_rst pulse or mid HOLD, and restarts from PLL_RST after release.

Test Plan:
Bench parameters: SYNC_STAGES=2, PLL_RST_CYCLES=3, TIMEOUT_CYCLES=20, STABLE_CYCLES=8, HOLD_CYCLES=4.
1. Release rst, pll_locked=0 throughout -> pll_rst high 3 cycles, low 20, high 3, repeating; timeout_count=1 after first timeout, 2 after second; reset_out=1, ready=0 throughout.
2. Release rst, pll_locked rises and is first sampled at edge S during WAIT_LOCK -> reset_out falls and ready rises exactly at edge S+14; counts stay 0; state=4.
3. In WAIT_LOCK, pll_locked high for 5 cycles then low, then high steadily from edge S2 -> reset_out never drops during the glitch; state returns to 1; counts unchanged; reset_out falls at S2+14.
4. In RUN, drop pll_locked before edge L -> reset_out=1, ready=0 at L+2; pll_rst high 3 cycles; loss_count=1; relock high from S3 -> reset_out falls at S3+14.
5. Hold pll_locked=0 for 300 timeouts -> timeout_count reaches 255 and stays 255; no wrap to 0.
6. Assert rst asynchronously mid-HOLD, between clock edges -> reset_out=1, pll_rst=1, ready=0, state=0, counts=0 before the next refclk edge.

Source files
------------

// File: rtl/pll_sdram_reset_seq.sv
// rtl/pll_sdram_reset_seq.sv - PLL reset pulse and lock-qualified reset sequencer for the SDRAM clock domains
module pll_sdram_reset_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16,
    parameter int CNT_W          = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       reset_out,
    output logic       ready,
    output logic [7:0] timeout_count,
    output logic [7:0] loss_count,
    output logic [2:0] state
);

    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_HOLD      = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic [2:0]             state_next;
    logic                   timeout_hit;
    logic                   loss_hit;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_next  = state;
        cnt_next    = cnt + CNT_W'(1);
        timeout_hit = 1'b0;
        loss_hit    = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (cnt == PLL_RST_LAST) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = ST_STABLE;
                    cnt_next   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next  = ST_PLL_RST;
                    cnt_next    = '0;
                    timeout_hit = 1'b1;
                end
            end
            ST_STABLE: begin
                // A drop here restarts the timeout window rather than re-pulsing the PLL.
                if (!locked_s) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                end
            end
            ST_HOLD: begin
                if (!locked_s) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            ST_RUN: begin
                cnt_next = '0;
                if (!locked_s) begin
                    state_next = ST_PLL_RST;
                    loss_hit   = 1'b1;
                end
            end
            default: begin
                state_next = ST_PLL_RST;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state         <= ST_PLL_RST;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            reset_out     <= 1'b1;
            ready         <= 1'b0;
            timeout_count <= 8'd0;
            loss_count    <= 8'd0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            pll_rst   <= (state_next == ST_PLL_RST);
            reset_out <= (state_next != ST_RUN);
            ready     <= (state_next == ST_RUN);
            if (timeout_hit && (timeout_count != 8'hFF)) begin
                timeout_count <= timeout_count + 8'd1;
            end
            if (loss_hit && (loss_count != 8'hFF)) begin
                loss_count <= loss_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_sdram_reset_seq.sv
// tb/tb_pll_sdram_reset_seq.sv - scoreboard bench for pll_sdram_reset_seq
module tb_pll_sdram_reset_seq;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       reset_out;
    logic       ready;
    logic [7:0] timeout_count;
    logic [7:0] loss_count;
    logic [2:0] state;

    localparam int SIG_PLL_RST = 0;
    localparam int SIG_RESET   = 1;
    localparam int SIG_READY   = 2;
    localparam int SIG_TMO     = 3;
    localparam int SIG_LOSS    = 4;
    localparam int SIG_STATE   = 5;

    pll_sdram_reset_seq #(
        .SYNC_STAGES   (2),
        .PLL_RST_CYCLES(3),
        .TIMEOUT_CYCLES(20),
        .STABLE_CYCLES (8),
        .HOLD_CYCLES   (4),
        .CNT_W         (17)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .reset_out    (reset_out),
        .ready        (ready),
        .timeout_count(timeout_count),
        .loss_count   (loss_count),
        .state        (state)
    );

    always #5 refclk = ~refclk;

    int cyc = 0;
    always @(posedge refclk) cyc = cyc + 1;

    typedef struct {
        int cyc;
        int sig;
        int val;
        bit asy;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic void expect_at(int c, int s, int v, bit a);
        sb.push_back('{cyc: c, sig: s, val: v, asy: a});
    endfunction

    function automatic string sig_name(int s);
        case (s)
            SIG_PLL_RST: return "pll_rst";
            SIG_RESET:   return "reset_out";
            SIG_READY:   return "ready";
            SIG_TMO:     return "timeout_count";
            SIG_LOSS:    return "loss_count";
            default:     return "state";
        endcase
    endfunction

    function automatic int actual(int s);
        case (s)
            SIG_PLL_RST: return int'(pll_rst);
            SIG_RESET:   return int'(reset_out);
            SIG_READY:   return int'(ready);
            SIG_TMO:     return int'(timeout_count);
            SIG_LOSS:    return int'(loss_count);
            default:     return int'(state);
        endcase
    endfunction

    function automatic void compare(exp_t e, bit late);
        int got;
        got = actual(e.sig);
        checks++;
        if (late) begin
            errors++;
            $display("FAIL %s missed at cycle %0d (now %0d)", sig_name(e.sig), e.cyc, cyc);
        end else if (got != e.val) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", sig_name(e.sig), e.cyc, got, e.val);
        end
    endfunction

    // Clocked monitor: compares every entry due after the most recent edge.
    initial begin
        forever begin
            @(negedge refclk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (!sb[i].asy && sb[i].cyc <= cyc) begin
                    compare(sb[i], sb[i].cyc < cyc);
                    sb.delete(i);
                end
            end
        end
    end

    // Asynchronous monitor: compares entries that must hold right after rst rises.
    initial begin
        forever begin
            @(posedge rst);
            #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].asy) begin
                    compare(sb[i], 1'b0);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_to(int e);
        while (cyc < e) @(negedge refclk);
    endtask

    task automatic do_reset(output int b);
        @(negedge refclk);
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        b = cyc;
    endtask

    task automatic expect_released(int c);
        expect_at(c - 1, SIG_RESET, 1, 0);
        expect_at(c - 1, SIG_READY, 0, 0);
        expect_at(c - 1, SIG_STATE, 3, 0);
        expect_at(c, SIG_RESET, 0, 0);
        expect_at(c, SIG_READY, 1, 0);
        expect_at(c, SIG_STATE, 4, 0);
        expect_at(c, SIG_PLL_RST, 0, 0);
    endtask

    int b;

    initial begin
        // Reset values while rst is held from time zero.
        expect_at(2, SIG_PLL_RST, 1, 0);
        expect_at(2, SIG_RESET, 1, 0);
        expect_at(2, SIG_READY, 0, 0);
        expect_at(2, SIG_TMO, 0, 0);
        expect_at(2, SIG_LOSS, 0, 0);
        expect_at(2, SIG_STATE, 0, 0);
        wait_to(3);

        // Test 1: no lock, pulse/timeout cadence of 3 high + 20 low.
        do_reset(b);
        expect_at(b + 1, SIG_PLL_RST, 1, 0);
        expect_at(b + 1, SIG_STATE, 0, 0);
        expect_at(b + 2, SIG_PLL_RST, 1, 0);
        expect_at(b + 3, SIG_PLL_RST, 0, 0);
        expect_at(b + 3, SIG_STATE, 1, 0);
        expect_at(b + 10, SIG_RESET, 1, 0);
        expect_at(b + 10, SIG_READY, 0, 0);
        expect_at(b + 22, SIG_PLL_RST, 0, 0);
        expect_at(b + 22, SIG_TMO, 0, 0);
        expect_at(b + 23, SIG_PLL_RST, 1, 0);
        expect_at(b + 23, SIG_STATE, 0, 0);
        expect_at(b + 23, SIG_TMO, 1, 0);
        expect_at(b + 25, SIG_PLL_RST, 1, 0);
        expect_at(b + 26, SIG_PLL_RST, 0, 0);
        expect_at(b + 26, SIG_STATE, 1, 0);
        expect_at(b + 45, SIG_TMO, 1, 0);
        expect_at(b + 46, SIG_TMO, 2, 0);
        expect_at(b + 46, SIG_PLL_RST, 1, 0);
        expect_at(b + 46, SIG_RESET, 1, 0);
        expect_at(b + 46, SIG_READY, 0, 0);
        wait_to(b + 47);

        // Test 2: clean lock first sampled at S = b+6, release at S+14.
        do_reset(b);
        wait_to(b + 5);
        pll_locked = 1'b1;
        expect_at(b + 7, SIG_STATE, 1, 0);
        expect_at(b + 8, SIG_STATE, 2, 0);
        expect_released(b + 20);
        expect_at(b + 20, SIG_TMO, 0, 0);
        expect_at(b + 20, SIG_LOSS, 0, 0);
        wait_to(b + 22);

        // Test 3: 5-cycle glitch, then steady lock from S2 = b+16.
        do_reset(b);
        wait_to(b + 4);
        pll_locked = 1'b1;
        expect_at(b + 9, SIG_STATE, 2, 0);
        expect_at(b + 9, SIG_RESET, 1, 0);
        expect_at(b + 11, SIG_RESET, 1, 0);
        expect_at(b + 12, SIG_STATE, 1, 0);
        expect_at(b + 12, SIG_RESET, 1, 0);
        expect_at(b + 12, SIG_TMO, 0, 0);
        wait_to(b + 9);
        pll_locked = 1'b0;
        wait_to(b + 15);
        pll_locked = 1'b1;
        expect_released(b + 30);
        expect_at(b + 30, SIG_TMO, 0, 0);
        expect_at(b + 30, SIG_LOSS, 0, 0);

        // Test 4: loss in RUN at L = b+36, relock from S3 = b+44.
        wait_to(b + 35);
        pll_locked = 1'b0;
        expect_at(b + 37, SIG_RESET, 0, 0);
        expect_at(b + 37, SIG_LOSS, 0, 0);
        expect_at(b + 38, SIG_RESET, 1, 0);
        expect_at(b + 38, SIG_READY, 0, 0);
        expect_at(b + 38, SIG_PLL_RST, 1, 0);
        expect_at(b + 38, SIG_STATE, 0, 0);
        expect_at(b + 38, SIG_LOSS, 1, 0);
        expect_at(b + 40, SIG_PLL_RST, 1, 0);
        expect_at(b + 41, SIG_PLL_RST, 0, 0);
        expect_at(b + 41, SIG_STATE, 1, 0);
        wait_to(b + 43);
        pll_locked = 1'b1;
        expect_released(b + 58);
        expect_at(b + 58, SIG_LOSS, 1, 0);
        wait_to(b + 60);

        // Test 5: 300 timeouts, one every 23 cycles; count saturates at 255.
        do_reset(b);
        expect_at(b + 23 * 254, SIG_TMO, 254, 0);
        expect_at(b + 23 * 255 - 1, SIG_TMO, 254, 0);
        expect_at(b + 23 * 255, SIG_TMO, 255, 0);
        expect_at(b + 23 * 256, SIG_TMO, 255, 0);
        expect_at(b + 23 * 300 - 1, SIG_TMO, 255, 0);
        expect_at(b + 23 * 300, SIG_TMO, 255, 0);
        expect_at(b + 23 * 300, SIG_STATE, 0, 0);

        // Test 6: lock from b+6905 reaches HOLD at b+6915; rst strikes mid-HOLD.
        wait_to(b + 6904);
        pll_locked = 1'b1;
        expect_at(b + 6916, SIG_STATE, 3, 0);
        expect_at(b + 6916, SIG_RESET, 1, 0);
        expect_at(b + 6916, SIG_TMO, 255, 0);
        wait_to(b + 6916);
        #1;
        expect_at(cyc, SIG_PLL_RST, 1, 1);
        expect_at(cyc, SIG_RESET, 1, 1);
        expect_at(cyc, SIG_READY, 0, 1);
        expect_at(cyc, SIG_STATE, 0, 1);
        expect_at(cyc, SIG_TMO, 0, 1);
        expect_at(cyc, SIG_LOSS, 0, 1);
        rst = 1'b1;
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        b = cyc;
        expect_at(b + 1, SIG_PLL_RST, 1, 0);
        expect_at(b + 1, SIG_STATE, 0, 0);
        expect_at(b + 3, SIG_STATE, 1, 0);
        wait_to(b + 6);

        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s never checked (due cycle %0d)", sig_name(sb[i].sig), sb[i].cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
